pe_array_feeder: RTL and testbench

- Front-end sequencer that drives the PE_array load/compute interface: current_64pixels, in_curr_enable, CB_select, abs_Control, ref_8R_32, change_ref, ref_input_Control.
- Per 32x32 current block it loads the current block, preloads a 32-row reference window, then steps the window down one row per candidate.
- Tells the downstream SAD stage when abs_outs is valid and which vertical candidate it belongs to.
- Sits between the current/search-window memories (valid/ready streams) and PE_array.

---
 rtl/me_pkg.sv | 29 ++
 rtl/feeder_out_reg.sv | 86 ++++++++
 rtl/pe_array_feeder.sv | 153 +++++++++++++++
 tb/tb_pe_array_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : me_pkg                                                           |
// | Brief   : Shared constants, FSM state type and PE_array abs_Control codes  |
// |           for the motion-estimation front end.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package me_pkg;

  localparam int PIXEL        = 8;   // bits per pixel
  localparam int X            = 32;  // pixels per row, rows per block
  localparam int Y            = 32;  // rows in the reference window
  localparam int BAND_WIDTH_X = 8;   // reference rows carried by one parallel beat
  localparam int CUR_BEATS    = 16;  // two rows per beat -> 32 rows
  localparam int REF_BEATS    = 4;   // eight rows per beat -> 32 rows

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_CUR = 3'd1,
    ST_LOAD_REF = 3'd2,
    ST_SEARCH   = 3'd3,
    ST_DRAIN    = 3'd4
  } feeder_state_e;

  localparam logic [1:0] ABS_HOLD = 2'b00;
  localparam logic [1:0] ABS_CALC = 2'b01;

endpackage
`default_nettype wire

// File: rtl/feeder_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : feeder_out_reg                                                   |
// | Brief   : Registered PE_array-side output stage. Turns accepted-beat       |
// |           strobes into one-cycle PE_array controls, holds data between     |
// |           beats and delays each compute cycle by one to flag abs_outs.     |
// | Ports   : cur_fire_i/cur_data_i        accepted current beat            |
// |           ref_fire_i/ref_par_i/ref_data_i accepted reference beat        |
// |           calc_i/cand_i                 beat requests a compute         |
// |           *_o                           PE_array and SAD-side outputs   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module feeder_out_reg
  import me_pkg::*;
#(
  parameter int CUR_W = 512,
  parameter int REF_W = 2048,
  parameter int CIW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cur_fire_i,
  input  logic [CUR_W-1:0] cur_data_i,
  input  logic             ref_fire_i,
  input  logic             ref_par_i,
  input  logic [REF_W-1:0] ref_data_i,
  input  logic             calc_i,
  input  logic [CIW-1:0]   cand_i,
  output logic [CUR_W-1:0] current_64pixels_o,
  output logic             in_curr_enable_o,
  output logic [1:0]       abs_Control_o,
  output logic [REF_W-1:0] ref_8R_32_o,
  output logic             change_ref_o,
  output logic             ref_input_Control_o,
  output logic             abs_valid_o,
  output logic [CIW-1:0]   cand_idx_o
);

  logic [CUR_W-1:0] cur_q;
  logic             ice_q;
  logic [1:0]       abs_ctrl_q;
  logic [REF_W-1:0] ref_q;
  logic             chg_q;
  logic             ric_q;
  logic [CIW-1:0]   cand_pipe_q;  // candidate of the compute currently on the outputs
  logic             abs_valid_q;
  logic [CIW-1:0]   cand_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= '0;
      ice_q       <= 1'b0;
      abs_ctrl_q  <= ABS_HOLD;
      ref_q       <= '0;
      chg_q       <= 1'b0;
      ric_q       <= 1'b0;
      cand_pipe_q <= '0;
      abs_valid_q <= 1'b0;
      cand_idx_q  <= '0;
    end else begin
      ice_q      <= cur_fire_i;
      chg_q      <= ref_fire_i;
      abs_ctrl_q <= calc_i ? ABS_CALC : ABS_HOLD;
      if (cur_fire_i) cur_q <= cur_data_i;
      if (ref_fire_i) begin
        ref_q <= ref_data_i;
        ric_q <= ref_par_i;
      end
      if (calc_i) cand_pipe_q <= cand_i;
      // PE_array produces abs_outs one cycle after a compute-on-update cycle.
      abs_valid_q <= (abs_ctrl_q == ABS_CALC) && chg_q;
      if ((abs_ctrl_q == ABS_CALC) && chg_q) cand_idx_q <= cand_pipe_q;
    end
  end

  assign current_64pixels_o  = cur_q;
  assign in_curr_enable_o    = ice_q;
  assign abs_Control_o       = abs_ctrl_q;
  assign ref_8R_32_o         = ref_q;
  assign change_ref_o        = chg_q;
  assign ref_input_Control_o = ric_q;
  assign abs_valid_o         = abs_valid_q;
  assign cand_idx_o          = cand_idx_q;

endmodule
`default_nettype wire

// File: rtl/pe_array_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pe_array_feeder                                                  |
// | Brief   : Per 32x32 block: loads the current block, preloads a 32-row      |
// |           reference window in parallel, then shifts the window down one    |
// |           row per vertical candidate, flagging each abs_outs result.       |
// | Ports   : start/busy/done                 block handshake                |
// |           cur_valid/cur_ready/cur_data    current-block stream           |
// |           ref_valid/ref_ready/ref_data    search-window stream           |
// |           current_64pixels..ref_input_Control  PE_array controls         |
// |           abs_valid/cand_idx              result tag for the SAD stage   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pe_array_feeder
  import me_pkg::*;
#(
  parameter int PIXEL       = me_pkg::PIXEL,
  parameter int X           = me_pkg::X,
  parameter int SEARCH_ROWS = 32,
  parameter int CIW         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   cur_valid,
  output logic                   cur_ready,
  input  logic [2*X*PIXEL-1:0]   cur_data,
  input  logic                   ref_valid,
  output logic                   ref_ready,
  input  logic [8*X*PIXEL-1:0]   ref_data,
  output logic [2*X*PIXEL-1:0]   current_64pixels,
  output logic                   in_curr_enable,
  output logic                   CB_select,
  output logic [1:0]             abs_Control,
  output logic [8*X*PIXEL-1:0]   ref_8R_32,
  output logic                   change_ref,
  output logic                   ref_input_Control,
  output logic                   abs_valid,
  output logic [CIW-1:0]         cand_idx
);

  localparam logic [CIW-1:0] LAST_CAND = CIW'(SEARCH_ROWS - 1);

  feeder_state_e  state_q;
  logic [3:0]     beat_q;
  logic [CIW-1:0] cand_q;
  logic           done_q;
  logic           cb_q;

  logic           cur_fire;
  logic           ref_fire;
  logic           ld_ref_fire;
  logic           srch_fire;
  logic           calc;
  logic [CIW-1:0] cand_sel;
  logic           last_result;

  assign cur_ready   = (state_q == ST_LOAD_CUR);
  assign ref_ready   = (state_q == ST_LOAD_REF) || (state_q == ST_SEARCH);
  assign cur_fire    = cur_ready && cur_valid;
  assign ref_fire    = ref_ready && ref_valid;
  assign ld_ref_fire = (state_q == ST_LOAD_REF) && ref_valid;
  assign srch_fire   = (state_q == ST_SEARCH) && ref_valid;
  // The final parallel beat completes the window, so it doubles as candidate 0.
  assign calc        = (ld_ref_fire && (beat_q == 4'(REF_BEATS - 1))) || srch_fire;
  assign cand_sel    = ld_ref_fire ? '0 : cand_q;
  // DRAIN waits until the last candidate's result leaves the output pipeline.
  assign last_result = abs_valid && (cand_idx == LAST_CAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      cand_q  <= '0;
      done_q  <= 1'b0;
      cb_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // done_q high means this is the done cycle; a start here is dropped.
          if (start && !done_q) begin
            state_q <= ST_LOAD_CUR;
            beat_q  <= '0;
            cand_q  <= '0;
          end
        end
        ST_LOAD_CUR: begin
          if (cur_fire) begin
            beat_q <= beat_q + 4'd1;  // wraps to 0 on the last beat
            if (beat_q == 4'(CUR_BEATS - 1)) state_q <= ST_LOAD_REF;
          end
        end
        ST_LOAD_REF: begin
          if (ref_fire) begin
            beat_q <= beat_q + 4'd1;
            if (beat_q == 4'(REF_BEATS - 1)) begin
              beat_q  <= '0;
              cand_q  <= CIW'(1);
              state_q <= (SEARCH_ROWS == 1) ? ST_DRAIN : ST_SEARCH;
            end
          end
        end
        ST_SEARCH: begin
          if (ref_fire) begin
            cand_q <= cand_q + CIW'(1);
            if (cand_q == LAST_CAND) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_result) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            cb_q    <= ~cb_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign CB_select = cb_q;

  feeder_out_reg #(
    .CUR_W (2*X*PIXEL),
    .REF_W (8*X*PIXEL),
    .CIW   (CIW)
  ) u_out_reg (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cur_fire_i          (cur_fire),
    .cur_data_i          (cur_data),
    .ref_fire_i          (ref_fire),
    .ref_par_i           (state_q == ST_LOAD_REF),
    .ref_data_i          (ref_data),
    .calc_i              (calc),
    .cand_i              (cand_sel),
    .current_64pixels_o  (current_64pixels),
    .in_curr_enable_o    (in_curr_enable),
    .abs_Control_o       (abs_Control),
    .ref_8R_32_o         (ref_8R_32),
    .change_ref_o        (change_ref),
    .ref_input_Control_o (ref_input_Control),
    .abs_valid_o         (abs_valid),
    .cand_idx_o          (cand_idx)
  );

endmodule
`default_nettype wire

// File: tb/tb_pe_array_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pe_array_feeder                                               |
// | Brief   : Self-checking bench: a block-level model (beat/candidate counts) |
// |           predicts every output each cycle for a SEARCH_ROWS=4 instance;  |
// |           a second SEARCH_ROWS=1 instance is checked by event counts.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pe_array_feeder;

  localparam int SR  = 4;
  localparam int CW  = 512;
  localparam int RW  = 2048;
  localparam int CIW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (SEARCH_ROWS=4)
  logic a_start = 1'b0, a_cur_valid = 1'b0, a_ref_valid = 1'b0;
  logic [CW-1:0] a_cur_data = '0;
  logic [RW-1:0] a_ref_data = '0;
  logic a_busy, a_done, a_cur_ready, a_ref_ready, a_ice, a_cb, a_chg, a_ric, a_av;
  logic [CW-1:0] a_cur64;
  logic [RW-1:0] a_ref8;
  logic [1:0] a_absc;
  logic [CIW-1:0] a_cand;

  // Instance B (SEARCH_ROWS=1)
  logic b_start = 1'b0, b_cur_valid = 1'b0, b_ref_valid = 1'b0;
  logic [CW-1:0] b_cur_data = '0;
  logic [RW-1:0] b_ref_data = '0;
  logic b_busy, b_done, b_cur_ready, b_ref_ready, b_ice, b_cb, b_chg, b_ric, b_av;
  logic [CW-1:0] b_cur64;
  logic [RW-1:0] b_ref8;
  logic [1:0] b_absc;
  logic [CIW-1:0] b_cand;

  pe_array_feeder #(.SEARCH_ROWS(SR), .CIW(CIW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .cur_valid(a_cur_valid), .cur_ready(a_cur_ready), .cur_data(a_cur_data),
    .ref_valid(a_ref_valid), .ref_ready(a_ref_ready), .ref_data(a_ref_data),
    .current_64pixels(a_cur64), .in_curr_enable(a_ice), .CB_select(a_cb),
    .abs_Control(a_absc), .ref_8R_32(a_ref8), .change_ref(a_chg),
    .ref_input_Control(a_ric), .abs_valid(a_av), .cand_idx(a_cand)
  );

  pe_array_feeder #(.SEARCH_ROWS(1), .CIW(CIW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .cur_valid(b_cur_valid), .cur_ready(b_cur_ready), .cur_data(b_cur_data),
    .ref_valid(b_ref_valid), .ref_ready(b_ref_ready), .ref_data(b_ref_data),
    .current_64pixels(b_cur64), .in_curr_enable(b_ice), .CB_select(b_cb),
    .abs_Control(b_absc), .ref_8R_32(b_ref8), .change_ref(b_chg),
    .ref_input_Control(b_ric), .abs_valid(b_av), .cand_idx(b_cand)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (low 128 bits, %0d bits differ) t=%0t",
               tag, obs[127:0], exp[127:0], $countones(obs ^ exp), $time);
    end
  endtask

  // Block-level reference model: progress is tracked as beat/candidate counts.
  bit m_active, m_cb, m_done_pend;
  int m_cur, m_ref, m_srch;
  bit p_cur_acc, p_ref_acc, p_ref_par, p_calc;
  logic [CW-1:0] p_cur_data;
  logic [RW-1:0] p_ref_data;
  int p_cand;
  bit q_calc;
  int q_cand;
  int cnt_ice, cnt_chg, cnt_av;
  bit seen_done;
  // stimulus knobs
  int vp_cur, vp_ref, stall_left;
  bit start_req, start_on_done, start_spam, stall_armed, pattern_mode;

  task automatic model_reset();
    m_active = 0; m_cb = 0; m_done_pend = 0;
    m_cur = 0; m_ref = 0; m_srch = 0;
    p_cur_acc = 0; p_ref_acc = 0; p_ref_par = 0; p_calc = 0; p_cand = 0;
    p_cur_data = '0; p_ref_data = '0;
    q_calc = 0; q_cand = 0; stall_left = 0;
  endtask

  task automatic cycle_a();
    bit e_busy, e_cr, e_rr, e_done;
    logic [3:0] k;
    logic [31:0] word;
    @(negedge clk);
    e_busy = m_active;
    e_cr   = m_active && (m_cur < 16);
    e_rr   = m_active && (m_cur == 16) && ((m_ref < 4) || (m_srch < SR - 1));
    e_done = m_done_pend;
    check_value("busy", a_busy, e_busy);
    check_value("done", a_done, e_done);
    check_value("cur_ready", a_cur_ready, e_cr);
    check_value("ref_ready", a_ref_ready, e_rr);
    check_value("CB_select", a_cb, m_cb);
    check_value("in_curr_enable", a_ice, p_cur_acc);
    if (p_cur_acc) check_value("current_64pixels", a_cur64, p_cur_data);
    check_value("change_ref", a_chg, p_ref_acc);
    if (p_ref_acc) begin
      check_value("ref_8R_32", a_ref8, p_ref_data);
      check_value("ref_input_Control", a_ric, p_ref_par);
    end
    check_value("abs_Control", a_absc, p_calc ? 2'b01 : 2'b00);
    check_value("abs_valid", a_av, q_calc);
    if (q_calc) check_value("cand_idx", a_cand, 8'(q_cand));
    cnt_ice += int'(a_ice);
    cnt_chg += int'(a_chg);
    cnt_av  += int'(a_av);
    if (a_done) seen_done = 1;

    // Result of the last candidate seen now -> done next cycle, block over.
    m_done_pend = q_calc && (q_cand == SR - 1);
    if (m_done_pend) begin
      m_active = 0;
      m_cb = ~m_cb;
    end
    q_calc = p_calc;
    q_cand = p_cand;

    // new stimulus for the coming edge
    a_start = (start_spam && e_busy) || (start_on_done && e_done);
    if (start_req && !e_busy && !e_done) begin
      a_start = 1;
      start_req = 0;
    end
    a_cur_valid = ($urandom_range(99) < vp_cur);
    if (stall_armed && m_srch == 1) begin
      stall_armed = 0;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      a_ref_valid = 0;
      stall_left--;
    end else begin
      a_ref_valid = ($urandom_range(99) < vp_ref);
    end
    if (pattern_mode) begin
      k = m_cur[3:0];
      word = {8{k}};
      a_cur_data = {16{word}};
    end else begin
      for (int w = 0; w < CW / 32; w++) a_cur_data[w*32 +: 32] = $urandom();
    end
    for (int w = 0; w < RW / 32; w++) a_ref_data[w*32 +: 32] = $urandom();

    p_cur_acc  = e_cr && a_cur_valid;
    p_cur_data = a_cur_data;
    if (p_cur_acc) m_cur++;
    p_ref_acc  = e_rr && a_ref_valid;
    p_ref_data = a_ref_data;
    p_ref_par  = (m_ref < 4);
    p_calc     = 0;
    if (p_ref_acc) begin
      if (m_ref < 4) begin
        p_calc = (m_ref == 3);
        p_cand = 0;
        m_ref++;
      end else begin
        p_calc = 1;
        m_srch++;
        p_cand = m_srch;
      end
    end
    if (a_start && !e_busy && !e_done) begin
      m_active = 1;
      m_cur = 0; m_ref = 0; m_srch = 0;
    end
  endtask

  task automatic run_block(input string name);
    start_req = 1;
    cnt_ice = 0; cnt_chg = 0; cnt_av = 0; seen_done = 0;
    for (int c = 0; c < 800 && !seen_done; c++) cycle_a();
    check_value({name, "_done_seen"}, seen_done, 1'b1);
    check_value({name, "_ice_count"}, cnt_ice, 16);
    check_value({name, "_chg_count"}, cnt_chg, 4 + SR - 1);
    check_value({name, "_av_count"}, cnt_av, SR);
  endtask

  initial begin
    bit hit;
    int b_ice_n, b_par_n, b_ser_n, b_av_n, b_av_t, b_done_t, b_cand0;
    model_reset();
    vp_cur = 100; vp_ref = 100;
    start_req = 0; start_on_done = 0; start_spam = 0; stall_armed = 0; pattern_mode = 0;

    // reset state
    #1;
    check_value("rst_ctrl", {a_busy, a_done, a_cur_ready, a_ref_ready, a_ice, a_cb,
                             a_absc, a_chg, a_ric, a_av, a_cand}, '0);
    check_value("rst_data", {a_cur64, a_ref8}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // block 1: patterned current beats, starts while busy and on done ignored
    pattern_mode = 1; start_spam = 1; start_on_done = 1;
    run_block("blk1");
    // block 2: back-to-back, 5-cycle ref stall inside SEARCH
    pattern_mode = 0; start_spam = 0; start_on_done = 0; stall_armed = 1;
    run_block("blk2");
    // random valid patterns
    vp_cur = 60; vp_ref = 55;
    for (int b = 0; b < 4; b++) run_block("rand");

    // reset asserted while candidate 2 is being computed
    vp_cur = 100; vp_ref = 100;
    start_req = 1; hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      cycle_a();
      if (p_calc && p_cand == 2) hit = 1;
    end
    check_value("reach_cand2", hit, 1'b1);
    cycle_a();
    #2 rst_n = 1'b0;
    #1;
    check_value("async_rst_ctrl", {a_busy, a_done, a_cur_ready, a_ref_ready, a_ice, a_cb,
                                   a_absc, a_chg, a_ric, a_av, a_cand}, '0);
    check_value("async_rst_data", {a_cur64, a_ref8}, '0);
    a_start = 0; a_cur_valid = 0; a_ref_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_value("no_done_in_rst", {a_done, a_av}, '0);
    end
    rst_n = 1'b1;
    model_reset();
    run_block("after_rst");

    // SEARCH_ROWS=1 instance
    for (int w = 0; w < CW / 32; w++) b_cur_data[w*32 +: 32] = $urandom();
    for (int w = 0; w < RW / 32; w++) b_ref_data[w*32 +: 32] = $urandom();
    b_ice_n = 0; b_par_n = 0; b_ser_n = 0; b_av_n = 0; b_av_t = -10; b_done_t = -1; b_cand0 = -1;
    @(negedge clk);
    b_start = 1; b_cur_valid = 1; b_ref_valid = 1;
    for (int i = 0; i < 200 && b_done_t < 0; i++) begin
      @(negedge clk);
      if (i == 0) b_start = 0;
      b_ice_n += int'(b_ice);
      if (b_chg && b_ric) b_par_n++;
      if (b_chg && !b_ric) b_ser_n++;
      if (b_av) begin
        b_av_n++;
        b_av_t = i;
        b_cand0 = int'(b_cand);
      end
      if (b_done) b_done_t = i;
    end
    check_value("sr1_ice_count", b_ice_n, 16);
    check_value("sr1_par_count", b_par_n, 4);
    check_value("sr1_shift_count", b_ser_n, 0);
    check_value("sr1_av_count", b_av_n, 1);
    check_value("sr1_cand", b_cand0, 0);
    check_value("sr1_done_after_av", b_done_t, b_av_t + 1);
    check_value("sr1_cb_toggled", b_cb, 1'b1);
    @(negedge clk);
    check_value("sr1_idle", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
